// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic definitions for the NTT datapath: default word width,
// the NTT prime and the divider's FSM state encoding.
package ntt_arith_pkg;

  // Default residue width; products are 2*NTT_DW bits wide.
  localparam int NTT_DW = 16;

  // NTT prime modulus.
  localparam int NTT_Q  = 12289;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div_32by16_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when no borrow.
module div_step #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] prem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] prem_o,
  output logic          q_o
);

  logic [DW:0]   shifted;
  logic [DW+1:0] diff;
  logic          unused_msb;

  // The trial word is DW+1 bits; diff carries one extra bit so the borrow is
  // a true borrow-out even when the divisor is zero (every step then sets the
  // quotient bit and the remainder ends up as the low dividend bits).
  assign shifted = {prem_i, bit_i};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_o     = ~diff[DW+1];

  // The kept residue is always below the divisor, so DW bits suffice; only
  // the divide-by-zero case overflows and there the low bits are what we want.
  assign prem_o  = q_o ? diff[DW-1:0] : shifted[DW-1:0];

  assign unused_msb = diff[DW] ^ shifted[DW];

endmodule

// File: rtl/seq_div_32by16.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one
// quotient bit per cycle, valid/ready on both sides.
// Optional: define SEQ_DIV_FAST_EN to finish divide-by-zero and
// dividend<divisor cases at acceptance instead of iterating.
module seq_div_32by16
  import ntt_arith_pkg::*;
#(
  parameter int DW    = NTT_DW,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(2*DW);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] dvd_q, dvd_d;   // dividend shifts out MSB, quotient in LSB
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   prem_q, prem_d;
  logic [2*DW-1:0] quo_q, quo_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [DW-1:0]   step_prem;
  logic            step_q;

  div_step #(.DW(DW)) u_step (
    .prem_i    (prem_q),
    .bit_i     (dvd_q[2*DW-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .q_o       (step_q)
  );

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update. Results are only written to the output
  // registers on the final step, so a partial quotient is never visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = '0;
          cnt_d   = ITERS;
          dbz_d   = 1'b0;
          state_d = BUSY;
`ifdef SEQ_DIV_FAST_EN
          // Trivial cases resolve immediately with the same values the
          // iteration would produce.
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend[DW-1:0];
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else if (dividend < {{DW{1'b0}}, divisor}) begin
            quo_d   = '0;
            rem_d   = dividend[DW-1:0];
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        dvd_d  = {dvd_q[2*DW-2:0], step_q};
        prem_d = step_prem;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = {dvd_q[2*DW-2:0], step_q};
          rem_d   = step_prem;
          dbz_d   = (dvs_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_div_32by16.sv
// Self-checking bench for seq_div_32by16: vector table with a scoreboard
// queue, plus backpressure and mid-operation reset sequences.
module tb_seq_div_32by16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  seq_div_32by16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [15:0] b);
`ifdef SEQ_DIV_FAST_EN
    if (b == 16'd0 || a < {16'd0, b}) return 1;
`endif
    return 32;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] b,
                              input logic [31:0] q, input logic [15:0] r, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.z = z; v.lat = exp_lat(a, b);
    return v;
  endfunction

  // Present one operation, accept it on the next rising edge, push expectation.
  task automatic start(input vec_t v);
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    if (v.lat > 1) chk("dbz_clear_on_accept", div_by_zero, 1'b0);
  endtask

  // Wait (bounded) for out_valid; count edges since acceptance.
  task automatic wait_result(output int lat);
    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input int lat);
    vec_t e;
    chk({nm, "_out_valid"}, out_valid, 1'b1);
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_latency"}, lat, e.lat);
      chk({nm, "_quotient"}, quotient, e.q);
      chk({nm, "_remainder"}, remainder, e.r);
      chk({nm, "_dbz"}, div_by_zero, e.z);
    end
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_out_valid_drop"}, out_valid, 1'b0);
    chk({nm, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int          lat;
    logic [31:0] ra;
    logic [15:0] rb;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 16'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    vecs.push_back(mk(32'h000F4240, 16'd7,     32'h00022E09, 16'd1,     1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 16'hFFFF,  32'h00010001, 16'd0,     1'b0));
    vecs.push_back(mk(32'hFFFE0001, 16'd12289, 32'h0005552E, 16'd2771,  1'b0));
    vecs.push_back(mk(32'h12345678, 16'd0,     32'hFFFFFFFF, 16'h5678,  1'b1));
    vecs.push_back(mk(32'd100,      16'd3,     32'd33,       16'd1,     1'b0));
    vecs.push_back(mk(32'd0,        16'd5,     32'd0,        16'd0,     1'b0));
    vecs.push_back(mk(32'd12289,    16'd12289, 32'd1,        16'd0,     1'b0));
    vecs.push_back(mk(32'd65534,    16'hFFFF,  32'd0,        16'd65534, 1'b0));
    vecs.push_back(mk(32'h0,        16'd0,     32'hFFFFFFFF, 16'd0,     1'b1));
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = 16'($urandom_range(1, 65535));
      vecs.push_back(mk(ra, rb, ra / {16'd0, rb}, 16'(ra % {16'd0, rb}), 1'b0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      start(vecs[i]);
      wait_result(lat);
      check_result($sformatf("vec%0d", i), lat);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held, inputs ignored while DONE
    start(mk(32'd5, 16'd9, 32'd0, 16'd5, 1'b0));
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'd1000;
      divisor  = 16'd1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_quotient", quotient, 32'd0);
      chk("bp_remainder", remainder, 16'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_result("bp", lat);
    handshake("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_ghost_op", in_ready, 1'b1);

    // Reset mid-operation
    start(mk(32'h000F4240, 16'd7, 32'h00022E09, 16'd1, 1'b0));
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 16'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start(mk(32'd100, 16'd3, 32'd33, 16'd1, 1'b0));
    wait_result(lat);
    check_result("post_rst", lat);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
